// File: rtl/servo_seq_ctrl.sv
// servo_seq_ctrl
// Four-channel servo pulse-length sequencer. A 1 us tick prescaler and a
// frame counter produce one frame_tick per frame. After each frame_tick the
// controller walks channels 0..3, one per cycle, moving each channel's pulse
// length toward its target by at most its per-frame step.
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   cmd_valid   command present
//   cmd_ready   command accepted this cycle if cmd_valid (high in IDLE)
//   cmd_ch      target channel 0..3
//   cmd_target  target pulse length in us
//   cmd_step    max change per frame in us, 0 = jump
//   pul_len     4 x 16-bit pulse lengths, ch i at [16i+15:16i]
//   moving      bit i high while ch i has not reached its target
//   frame_tick  one-cycle pulse at each frame boundary
//
// Build option
//   SERVO_LIMIT_EN  when defined, cmd_target is clamped to [MIN_US, MAX_US]
//                   as it is accepted; otherwise it is stored unmodified.
module servo_seq_ctrl #(
  parameter int unsigned CLK_F     = 50,
  parameter int unsigned FRAME_US  = 20000,
  parameter int unsigned CENTER_US = 1500,
  parameter int unsigned MIN_US    = 500,
  parameter int unsigned MAX_US    = 2500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_ch,
  input  logic [15:0] cmd_target,
  input  logic [7:0]  cmd_step,
  output logic [63:0] pul_len,
  output logic [3:0]  moving,
  output logic        frame_tick
);

  // state  | meaning
  // IDLE   | waiting for frame_tick, commands accepted
  // UPDATE | stepping channel idx_q toward its target, commands held off

  localparam int unsigned PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;
  localparam int unsigned TW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_F - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_US - 1);
  localparam logic [15:0]   CENTER    = 16'(CENTER_US);
  localparam logic [15:0]   MIN_V     = 16'(MIN_US);
  localparam logic [15:0]   MAX_V     = 16'(MAX_US);

`ifdef SERVO_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [1:0]        rel_q, rel_d;
  logic [3:0][15:0]  cur_q, cur_d;
  logic [3:0][15:0]  tgt_q, tgt_d;
  logic [3:0][7:0]   step_q, step_d;
  logic [3:0]        mov_q, mov_d;

  logic [15:0]       acc_tgt;
  logic [15:0]       sel_cur, sel_tgt, upd_cur;
  logic [7:0]        sel_step;
  logic [16:0]       diff;     // two's complement, target - current
  logic [16:0]       mag;

  // rel_q shifts ones in after reset release; the timebase starts counting
  // only once both stages are set, so the first frame is a full
  // CLK_F*FRAME_US cycles measured from the first edge after release.
  assign rel_d = {rel_q[0], 1'b1};

  always_comb begin
    pre_d  = pre_q;
    tick_d = tick_q;
    if (rel_q[1]) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  assign frame_tick = rel_q[1] && (pre_q == PRE_LAST) && (tick_q == TICK_LAST);

  always_comb begin
    acc_tgt = cmd_target;
    if (LIMIT_EN && (cmd_target < MIN_V)) begin
      acc_tgt = MIN_V;
    end else if (LIMIT_EN && (cmd_target > MAX_V)) begin
      acc_tgt = MAX_V;
    end
  end

  // Per-channel step. The difference is carried in 17 bits so a full-scale
  // swing (0 <-> 65535) neither wraps nor picks the wrong direction.
  always_comb begin
    sel_cur  = cur_q[idx_q];
    sel_tgt  = tgt_q[idx_q];
    sel_step = step_q[idx_q];
    diff     = {1'b0, sel_tgt} - {1'b0, sel_cur};
    mag      = diff[16] ? (~diff + 17'd1) : diff;
    if ((sel_step == 8'd0) || (mag <= {9'd0, sel_step})) begin
      upd_cur = sel_tgt;
    end else if (diff[16]) begin
      upd_cur = sel_cur - {8'd0, sel_step};
    end else begin
      upd_cur = sel_cur + {8'd0, sel_step};
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    mov_d     = mov_q;
    cmd_ready = (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_d[cmd_ch]  = acc_tgt;
          step_d[cmd_ch] = cmd_step;
        end
        // A command taken in the frame_tick cycle lands before the pass
        // starts, so the pass already uses it.
        if (frame_tick) begin
          state_d = UPDATE;
          idx_d   = 2'd0;
        end
      end
      UPDATE: begin
        cur_d[idx_q] = upd_cur;
        mov_d[idx_q] = (upd_cur != sel_tgt);
        if (idx_q == 2'd3) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
      tick_q  <= '0;
      rel_q   <= '0;
      cur_q   <= {4{CENTER}};
      tgt_q   <= {4{CENTER}};
      step_q  <= '0;
      mov_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      rel_q   <= rel_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      mov_q   <= mov_d;
    end
  end

  assign pul_len = cur_q;
  assign moving  = mov_q;

endmodule

// File: tb/tb_servo_seq_ctrl.sv
module tb_servo_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ch;
  logic [15:0] cmd_target;
  logic [7:0]  cmd_step;
  logic [63:0] pul_len;
  logic [3:0]  moving;
  logic        frame_tick;

  servo_seq_ctrl #(
    .CLK_F     (2),
    .FRAME_US  (10),
    .CENTER_US (1500),
    .MIN_US    (500),
    .MAX_US    (2500)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .pul_len    (pul_len),
    .moving     (moving),
    .frame_tick (frame_tick)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        do_cmd;
    logic [1:0]  ch;
    logic [15:0] tgt;
    logic [7:0]  stp;
    logic [63:0] exp_pul;
    logic [3:0]  exp_mov;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

`ifdef SERVO_LIMIT_EN
  localparam logic [15:0] C0_JUMP = 16'd2500;
  localparam logic [15:0] C0_DN1  = 16'd2245;
  localparam logic [15:0] C0_TOP  = 16'd2500;
  localparam logic [15:0] C0_DN2  = 16'd2245;
  localparam logic [15:0] C0_RED  = 16'd2345;
`else
  localparam logic [15:0] C0_JUMP = 16'd3000;
  localparam logic [15:0] C0_DN1  = 16'd2745;
  localparam logic [15:0] C0_TOP  = 16'd65535;
  localparam logic [15:0] C0_DN2  = 16'd65280;
  localparam logic [15:0] C0_RED  = 16'd65380;
`endif

  function automatic logic [63:0] pl(input logic [15:0] c0, input logic [15:0] c1,
                                     input logic [15:0] c2, input logic [15:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic vec_t mk(input logic d, input logic [1:0] ch, input logic [15:0] t,
                              input logic [7:0] s, input logic [63:0] ep, input logic [3:0] em);
    vec_t v;
    v.do_cmd = d; v.ch = ch; v.tgt = t; v.stp = s; v.exp_pul = ep; v.exp_mov = em;
    return v;
  endfunction

  task automatic step_clk();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step_clk();
      seen = (frame_tick === 1'b1);
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no frame_tick within 60 cycles", name);
    end
  endtask

  task automatic send_cmd(input logic [1:0] ch, input logic [15:0] t, input logic [7:0] s,
                          input string name);
    check({name, "_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_ch     = ch;
    cmd_target = t;
    cmd_step   = s;
    step_clk();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    int first;
    int cnt;

    vecs[0]  = mk(1'b1, 2'd1, 16'd1600,  8'd30,  pl(1500, 1530, 1500, 1500), 4'b0010);
    vecs[1]  = mk(1'b0, 2'd0, 16'd0,     8'd0,   pl(1500, 1560, 1500, 1500), 4'b0010);
    vecs[2]  = mk(1'b0, 2'd0, 16'd0,     8'd0,   pl(1500, 1590, 1500, 1500), 4'b0010);
    vecs[3]  = mk(1'b0, 2'd0, 16'd0,     8'd0,   pl(1500, 1600, 1500, 1500), 4'b0000);
    vecs[4]  = mk(1'b1, 2'd2, 16'd1000,  8'd0,   pl(1500, 1600, 1000, 1500), 4'b0000);
    vecs[5]  = mk(1'b1, 2'd3, 16'd1400,  8'd50,  pl(1500, 1600, 1000, 1450), 4'b1000);
    vecs[6]  = mk(1'b1, 2'd3, 16'd1450,  8'd50,  pl(1500, 1600, 1000, 1450), 4'b0000);
    vecs[7]  = mk(1'b1, 2'd0, 16'd3000,  8'd0,   pl(C0_JUMP, 1600, 1000, 1450), 4'b0000);
    vecs[8]  = mk(1'b1, 2'd0, 16'd100,   8'd255, pl(C0_DN1, 1600, 1000, 1450), 4'b0001);
    vecs[9]  = mk(1'b1, 2'd0, 16'd65535, 8'd0,   pl(C0_TOP, 1600, 1000, 1450), 4'b0000);
    vecs[10] = mk(1'b1, 2'd0, 16'd0,     8'd255, pl(C0_DN2, 1600, 1000, 1450), 4'b0001);
    vecs[11] = mk(1'b1, 2'd0, 16'd65535, 8'd100, pl(C0_RED, 1600, 1000, 1450), 4'b0001);
    vecs[12] = mk(1'b1, 2'd0, 16'd1500,  8'd0,   pl(1500, 1600, 1000, 1450), 4'b0000);

    RST        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_ch     = 2'd0;
    cmd_target = 16'd0;
    cmd_step   = 8'd0;

    // reset values while held in reset
    #12;
    check("rst_pul",   pul_len, pl(1500, 1500, 1500, 1500));
    check("rst_mov",   64'(moving), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_tick",  64'(frame_tick), 64'd0);

    // release on a falling edge; first frame_tick 20 cycles after the first rising edge
    #8;
    RST = 1'b0;
    first = 0;
    for (int k = 1; k <= 60 && first == 0; k++) begin
      step_clk();
      if (frame_tick === 1'b1) first = k;
    end
    check("first_tick_edge", 64'(first), 64'd21);

    cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      step_clk();
      cnt++;
      if (frame_tick === 1'b1) break;
    end
    check("tick_period", 64'(cnt), 64'd20);
    repeat (5) step_clk();
    check("idle_pass_pul", pul_len, pl(1500, 1500, 1500, 1500));

    // table: optional command, then one full update pass, then compare
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_cmd) send_cmd(vecs[i].ch, vecs[i].tgt, vecs[i].stp, $sformatf("vec%0d", i));
      wait_tick($sformatf("vec%0d_tick", i));
      repeat (5) step_clk();
      check($sformatf("vec%0d_pul", i), pul_len, vecs[i].exp_pul);
      check($sformatf("vec%0d_mov", i), 64'(moving), 64'(vecs[i].exp_mov));
    end

    // command accepted in the frame_tick cycle is used by that pass; ch1 updates at end of T+2
    wait_tick("same_cycle_tick");
    check("same_cycle_ready", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_ch     = 2'd1;
    cmd_target = 16'd1550;
    cmd_step   = 8'd0;
    step_clk();
    cmd_valid  = 1'b0;
    step_clk();
    check("same_cycle_ch1_before", 64'(pul_len[31:16]), 64'd1600);
    step_clk();
    check("same_cycle_ch1_after", 64'(pul_len[31:16]), 64'd1550);
    check("same_cycle_mov", 64'(moving), 64'd0);
    repeat (2) step_clk();

    // backpressure: valid held from T+1, ready low T+1..T+4, accepted at end of T+5
    wait_tick("bp_tick");
    step_clk();
    cmd_valid  = 1'b1;
    cmd_ch     = 2'd3;
    cmd_target = 16'd1700;
    cmd_step   = 8'd0;
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("bp_ready_T%0d", j), 64'(cmd_ready), 64'd0);
      step_clk();
    end
    check("bp_ready_T5", 64'(cmd_ready), 64'd1);
    step_clk();
    cmd_valid = 1'b0;
    check("bp_hold_pul", pul_len, pl(1500, 1550, 1000, 1450));
    wait_tick("bp_apply_tick");
    repeat (5) step_clk();
    check("bp_apply_pul", pul_len, pl(1500, 1550, 1000, 1700));
    check("bp_apply_mov", 64'(moving), 64'd0);

    // asynchronous reset in the middle of an update pass during a ch1 ramp
    send_cmd(2'd1, 16'd2000, 8'd30, "ramp2");
    wait_tick("arst_tick");
    repeat (3) step_clk();
    check("arst_pre_ch1", 64'(pul_len[31:16]), 64'd1580);
    check("arst_pre_mov", 64'(moving), 64'b0010);
    #2;
    RST = 1'b1;
    #1;
    check("arst_pul",   pul_len, pl(1500, 1500, 1500, 1500));
    check("arst_mov",   64'(moving), 64'd0);
    check("arst_ready", 64'(cmd_ready), 64'd1);
    check("arst_tick",  64'(frame_tick), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    wait_tick("post_rst_tick");
    repeat (5) step_clk();
    check("post_rst_pul", pul_len, pl(1500, 1500, 1500, 1500));
    check("post_rst_mov", 64'(moving), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/servo_seq_ctrl.md
SERVO_SEQ_CTRL -- requirements
Module: servo_seq_ctrl

Interface
REQ-001 SHALL have parameter CLK_F, default 50, giving clock cycles per 1 us tick.
REQ-002 SHALL have parameter FRAME_US, default 20000, giving frame length in ticks.
REQ-003 SHALL have parameter CENTER_US, default 1500, giving the reset pulse length.
REQ-004 SHALL have parameters MIN_US and MAX_US, defaults 500 and 2500, giving the clamp limits.
REQ-005 SHALL have port CLK, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port cmd_valid, input, 1 bit: command present.
REQ-008 SHALL have port cmd_ready, output, 1 bit: command can be accepted this cycle.
REQ-009 SHALL have port cmd_ch, input, 2 bits: target channel, 0..3.
REQ-010 SHALL have port cmd_target, input, 16 bits: target pulse length in us.
REQ-011 SHALL have port cmd_step, input, 8 bits: maximum change per frame in us; 0 means jump.
REQ-012 SHALL have port pul_len, output, 64 bits: four 16-bit pulse lengths, ch i at [16i+15:16i], one per servo PWM generator.
REQ-013 SHALL have port moving, output, 4 bits: bit i high while ch i current differs from its target.
REQ-014 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-015 SHALL count CLK_F cycles per tick and FRAME_US ticks per frame; frame_tick high in the cycle where prescaler==CLK_F-1 and tick count==FRAME_US-1.
REQ-016 SHALL use FSM states IDLE and UPDATE: IDLE->UPDATE on the edge ending a frame_tick cycle; UPDATE visits channel index 0..3, one per cycle, then returns to IDLE.
REQ-017 SHALL drive cmd_ready = (state==IDLE); a command SHALL be accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-018 SHALL, on acceptance, write cmd_target and cmd_step into the per-channel registers of channel cmd_ch on that edge; other channels SHALL be unchanged.
REQ-019 SHALL, with frame_tick high in cycle T, update ch i current at the end of cycle T+1+i.
REQ-020 SHALL perform each update as follows:
  - step==0 or |target-current|<=step: current:=target
  - otherwise: current moves step toward target
  - the difference SHALL be computed 17-bit signed, with no wrap.
REQ-021 SHALL update moving[i] in the same edge as ch i current, as (new current != target).
REQ-022 SHALL, on a command accepted during a frame_tick cycle T, use the new target for the update pass starting at T+1.
REQ-023 SHALL, on a new command to a moving channel, replace target and step; motion continues from the present current value with no jump.
REQ-024 SHALL, on a command equal to current, leave current unchanged; moving[i] clears at the next update.
REQ-025 SHALL never alter pul_len outside UPDATE or reset.

Reset
REQ-026 SHALL, while RST is high, immediately set the following regardless of state, including mid-UPDATE:
  - every pul_len channel and every target = CENTER_US
  - every step = 0
  - moving = 0, frame_tick = 0
  - prescaler and tick counters = 0
  - state = IDLE, hence cmd_ready = 1.
REQ-027 SHALL assert the first frame_tick after reset release CLK_F*FRAME_US cycles after the first clock edge following release.

Configuration
REQ-028 SHALL clamp cmd_target to [MIN_US, MAX_US] at acceptance when macro SERVO_LIMIT_EN is defined.
REQ-029 SHALL store cmd_target unmodified when SERVO_LIMIT_EN is not defined.

Verification (bench uses CLK_F=2, FRAME_US=10: frame_tick every 20 cycles)
REQ-030 SHALL check reset: release RST -> pul_len = 4x1500, moving=0, cmd_ready=1, first frame_tick 20 cycles later.
REQ-031 SHALL check ramp: ch1 target 1600 step 30 -> ch1 reads 1530, 1560, 1590, 1600 on four successive frames; moving[1] falls with the 1600 update; other channels stay 1500.
REQ-032 SHALL check jump: ch2 target 1000 step 0 -> ch2=1000 at T+3 after the next frame_tick; moving[2] stays low after that update.
REQ-033 SHALL check backpressure: cmd_valid held from tick cycle T+1 -> cmd_ready low during T+1..T+4; command accepted at the end of T+5.
REQ-034 SHALL check limits: ch0 target 3000 step 0 -> ch0=2500 with SERVO_LIMIT_EN; ch0=3000 without it.
REQ-035 SHALL check async reset: RST pulse mid-UPDATE during a ch1 ramp -> all channels 1500 and moving=0 before the next clock edge.
